cacheline_adaptor: RTL
======================

Name: cacheline_adaptor

Overview:
- Sits between the L1 cache datapath/controller (pmem_* side) and the physical-memory burst interface.
- Converts a single 256-bit cacheline read or write into a 4-beat, 64-bit burst transaction.
- Presents one `resp_o` pulse to the cache per completed line transfer.
- Both the cache side and the memory side are request/response handshakes with no pipelining: one transaction is outstanding at a time.

Parameters:
- LINE_W, 256, cacheline width in bits.
- BURST_W, 64, memory beat width in bits; BEATS = LINE_W/BURST_W (4). LINE_W must be an integer multiple of BURST_W.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- line_i  in  LINE_W  write data from cache.
- line_o  out  LINE_W  assembled read line to cache.
- address_i  in  ADDR_W  line address from cache.
- read_i  in  1  cache line-read request (level, held until resp_o).
- write_i  in  1  cache line-write request (level, held until resp_o).
- resp_o  out  1  one-cycle completion pulse to cache.
- burst_i  in  BURST_W  read beat from memory.
- burst_o  out  BURST_W  write beat to memory.
- address_o  out  ADDR_W  line-aligned address to memory.
- read_o  out  1  memory burst-read request.
- write_o  out  1  memory burst-write request.
- resp_i  in  1  memory beat strobe; one beat transferred per cycle it is high.

Behaviour:
- Reset value on `rst`=0, asynchronous: state IDLE; beat counter 0; all outputs 0 (line_o, burst_o, address_o, read_o, write_o, resp_o).
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- States: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
- IDLE:
  - Sample `write_i`/`read_i`. `write_i` has priority if both are high.
  - On accept: latch `address_i`, clearing the low log2(LINE_W/8) bits (5), into `address_o`.
  - On a write: also latch `line_i` into the write buffer.
  - Clear the beat counter.
  - Go to WR_BURST or RD_BURST.
  - `resp_i` is ignored in IDLE.
- RD_BURST:
  - `read_o`=1 from the first cycle in the state.
  - Each cycle `resp_i`=1: write `burst_i` into line slice [cnt*BURST_W +: BURST_W], then cnt++.
  - Gaps (`resp_i`=0) are allowed and hold state.
  - When the beat with cnt==BEATS-1 is captured, go to RD_DONE. `read_o` deasserts in the same transition.
- RD_DONE:
  - `resp_o`=1 for exactly one cycle; `line_o` holds the complete line.
  - Then go to IDLE.
  - `line_o` stays stable until the first beat of the next read overwrites it.
- WR_BURST:
  - `write_o`=1; `burst_o` = write buffer slice [cnt].
  - Each cycle `resp_i`=1, cnt++ and `burst_o` advances to the next slice on the next cycle.
  - After beat BEATS-1 is accepted, go to WR_DONE with `write_o`=0.
- WR_DONE: `resp_o`=1 for one cycle, then go to IDLE.
- Requests arriving while busy are ignored. The cache holds them level-sensitive, so they are seen on return to IDLE.
- The cache drops its request the cycle after `resp_o`. A request still high in the IDLE cycle after DONE starts a new transaction; this is legal.
- `resp_i` asserted in DONE or IDLE is ignored and produces no extra capture.
- Counter width is log2(BEATS). There is no wrap-around within a transaction, because the state leaves BURST on the final beat.
- Minimum latency: request sampled at cycle T0 → `read_o`/`write_o` at T1 → 4 back-to-back beats T1..T4 → `resp_o` at T5.
- Reset mid-burst: immediate return to IDLE with all outputs 0; the partial line is discarded and `line_o` is cleared.

Test Plan:
1. Reset release, then `read_i`=1 with `address_i`=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back → `address_o`=0x0000_1220, `read_o` high 4 cycles, `resp_o` pulse at T5, `line_o`={0x44..,0x33..,0x22..,0x11..} (beat 0 in the LSBs).
2. `write_i`=1 with `line_i`=0xDDDD..CCCC..BBBB..AAAA (64-bit slices) → `burst_o` sequence 0xAAAA..→0xBBBB..→0xCCCC..→0xDDDD.. on successive `resp_i` beats; `write_o` drops after beat 3; one `resp_o` pulse.
3. Read with `resp_i` gaps (pattern 1,0,0,1,1,0,1) → exactly 4 captures in order; `resp_o` one cycle after the 4th beat; `read_o` held high through the gaps.
4. `read_i` and `write_i` both high in IDLE → write burst only; `read_o` stays 0 throughout.
5. `rst` pulled low after beat 2 of a read → next cycle all outputs 0 and state IDLE; a new read after release completes normally with correct data.
6. `resp_i` held high for 2 extra cycles after the final beat, and `read_i` held one cycle after `resp_o` → no corrupted `line_o`, exactly one `resp_o` per transaction; the second transaction starts cleanly.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: splits a cacheline read/write into a multi-beat memory burst and reassembles read beats.
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);
  localparam int BEATS = LINE_W / BURST_W;
  localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int OFF   = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'((1 << OFF) - 1);
  typedef enum logic [2:0] {IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE} state_t;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [LINE_W-1:0] wbuf;
  logic              last;
  assign last    = cnt == CW'(BEATS - 1);
  assign burst_o = state == WR_BURST ? wbuf[cnt*BURST_W +: BURST_W] : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wbuf      <= '0;
      line_o    <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_o <= 1'b0;
          cnt    <= '0;
          if (write_i) begin
            wbuf      <= line_i;
            address_o <= address_i & ALIGN;
            write_o   <= 1'b1;
            state     <= WR_BURST;
          end else if (read_i) begin
            address_o <= address_i & ALIGN;
            read_o    <= 1'b1;
            state     <= RD_BURST;
          end
        end
        RD_BURST: if (resp_i) begin
          line_o[cnt*BURST_W +: BURST_W] <= burst_i;
          cnt <= cnt + 1'b1;
          if (last) begin
            read_o <= 1'b0;
            resp_o <= 1'b1;
            state  <= RD_DONE;
          end
        end
        WR_BURST: if (resp_i) begin
          cnt <= cnt + 1'b1;
          if (last) begin
            write_o <= 1'b0;
            resp_o  <= 1'b1;
            state   <= WR_DONE;
          end
        end
        RD_DONE, WR_DONE: begin
          resp_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
